// File: rtl/exe_wb_stage_pkg.sv
// Shared widths, opcode classes and the write-class decode for the EXE drain stage.
package exe_wb_stage_pkg;
    localparam int DSIZE_D = 32;
    localparam int ASIZE_D = 5;

    localparam logic [1:0] OPC_RTYPE  = 2'b00;
    localparam logic [1:0] OPC_ITYPE  = 2'b01;
    localparam logic [1:0] OPC_STORE  = 2'b10;
    localparam logic [1:0] OPC_BRANCH = 2'b11;

    // Takes the class field exe_op[5:4]; only R/I-type results touch the register file.
    function automatic logic is_writing(input logic [1:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_ITYPE);
    endfunction
endpackage

// File: rtl/exe_wb_stage_wb_fifo2.sv
// Two-entry {waddr,wdata} FIFO with 1-bit wrapping pointers and raw entry peek for forwarding.
module wb_fifo2 #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DW-1:0]         i_wdata,
    input  logic                  i_pop,
    output logic [1:0]            o_count,
    output logic                  o_rd_ptr,
    output logic                  o_wr_ptr,
    output logic [AW-1:0]         o_head_waddr,
    output logic [DW-1:0]         o_head_wdata,
    output logic [1:0][AW-1:0]    o_waddr,
    output logic [1:0][DW-1:0]    o_wdata
);
    logic [1:0][AW-1:0] r_waddr;
    logic [1:0][DW-1:0] r_wdata;
    logic [1:0]         r_count;
    logic               r_rd_ptr, r_wr_ptr;
    logic               w_push, w_pop;

    assign w_push = i_push && (r_count != 2'd2);
    assign w_pop  = i_pop  && (r_count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_waddr[r_wr_ptr] <= i_waddr;
                r_wdata[r_wr_ptr] <= i_wdata;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_rd_ptr     = r_rd_ptr;
    assign o_wr_ptr     = r_wr_ptr;
    assign o_head_waddr = r_waddr[r_rd_ptr];
    assign o_head_wdata = r_wdata[r_rd_ptr];
    assign o_waddr      = r_waddr;
    assign o_wdata      = r_wdata;
endmodule

// File: rtl/exe_wb_stage.sv
// EXE drain: accepts results, queues register-file writes, forwards pending writes to ID.
module exe_wb_stage
    import exe_wb_stage_pkg::*;
#(
    parameter int DSIZE = DSIZE_D,
    parameter int ASIZE = ASIZE_D,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exe_valid,
    output logic             exe_ready,
    input  logic [DSIZE-1:0] exe_result,
    input  logic [ASIZE-1:0] exe_waddr,
    input  logic [5:0]       exe_op,
    output logic             wb_wen,
    input  logic             wb_ready,
    output logic [ASIZE-1:0] wb_waddr,
    output logic [DSIZE-1:0] wb_wdata,
    input  logic [ASIZE-1:0] rs_a,
    input  logic [ASIZE-1:0] rs_b,
    output logic             fwd_a_hit,
    output logic [DSIZE-1:0] fwd_a_data,
    output logic             fwd_b_hit,
    output logic [DSIZE-1:0] fwd_b_data,
    output logic [CNTW-1:0]  retired_cnt
);
    logic [1:0]            w_count;
    logic                  w_rd_ptr, w_wr_ptr;
    logic [ASIZE-1:0]      w_head_waddr;
    logic [DSIZE-1:0]      w_head_wdata;
    logic [1:0][ASIZE-1:0] w_ent_waddr;
    logic [1:0][DSIZE-1:0] w_ent_wdata;
    logic                  w_accept, w_push, w_pop;
    logic                  w_unused_op;
    logic [CNTW-1:0]       r_retired;

    assign w_unused_op = ^exe_op[3:0];

    // Ready depends only on registered occupancy, never on wb_ready.
    assign exe_ready = rst && (w_count != 2'd2);
    assign w_accept  = exe_valid && exe_ready;
    assign w_push    = w_accept && is_writing(exe_op[5:4]) && (exe_waddr != '0);
    assign wb_wen    = (w_count != 2'd0);
    assign w_pop     = wb_wen && wb_ready;
    assign wb_waddr  = wb_wen ? w_head_waddr : '0;
    assign wb_wdata  = wb_wen ? w_head_wdata : '0;

    wb_fifo2 #(.DW(DSIZE), .AW(ASIZE)) u_fifo (
        .clk          (clk),
        .rst_n        (rst),
        .i_push       (w_push),
        .i_waddr      (exe_waddr),
        .i_wdata      (exe_result),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_rd_ptr     (w_rd_ptr),
        .o_wr_ptr     (w_wr_ptr),
        .o_head_waddr (w_head_waddr),
        .o_head_wdata (w_head_wdata),
        .o_waddr      (w_ent_waddr),
        .o_wdata      (w_ent_wdata)
    );

    // Newest entry sits just behind the write pointer; it wins over the head when both match.
    function automatic logic [DSIZE:0] fwd_lookup(input logic [ASIZE-1:0] rs);
        logic [DSIZE:0] res;
        res = '0;
        if (rs != '0) begin
            if ((w_count != 2'd0) && (w_ent_waddr[~w_wr_ptr] == rs))
                res = {1'b1, w_ent_wdata[~w_wr_ptr]};
            else if ((w_count == 2'd2) && (w_ent_waddr[w_rd_ptr] == rs))
                res = {1'b1, w_ent_wdata[w_rd_ptr]};
        end
        return res;
    endfunction

    assign {fwd_a_hit, fwd_a_data} = fwd_lookup(rs_a);
    assign {fwd_b_hit, fwd_b_data} = fwd_lookup(rs_b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_retired <= '0;
        else if (w_accept) r_retired <= r_retired + 1'b1;
    end

    assign retired_cnt = r_retired;
endmodule

// File: tb/tb_exe_wb_stage.sv
// Directed bench for exe_wb_stage: handshake, FIFO order, forwarding, reset and counter wrap.
module tb_exe_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid;
    logic        exe_ready;
    logic [31:0] exe_result;
    logic [4:0]  exe_waddr;
    logic [5:0]  exe_op;
    logic        wb_wen;
    logic        wb_ready;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [4:0]  rs_a, rs_b;
    logic        fwd_a_hit, fwd_b_hit;
    logic [31:0] fwd_a_data, fwd_b_data;
    logic [15:0] retired_cnt;

    int compared = 0;
    int mismatched = 0;

    exe_wb_stage dut (
        .clk(clk), .rst(rst),
        .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_result(exe_result),
        .exe_waddr(exe_waddr), .exe_op(exe_op),
        .wb_wen(wb_wen), .wb_ready(wb_ready), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .rs_a(rs_a), .rs_b(rs_b),
        .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
        .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] wa, input logic [31:0] d);
        exe_valid  = v;
        exe_op     = op;
        exe_waddr  = wa;
        exe_result = d;
    endtask

    initial begin
        rst = 1'b0; wb_ready = 1'b1; rs_a = 5'd0; rs_b = 5'd0;
        drive(1'b1, 6'h00, 5'd5, 32'h1234_5678);
        repeat (3) tick();
        chk("rst_exe_ready", {31'd0, exe_ready}, 32'd0);
        chk("rst_wb_wen",    {31'd0, wb_wen},    32'd0);
        chk("rst_retired",   {16'd0, retired_cnt}, 32'd0);
        chk("rst_wb_waddr",  {27'd0, wb_waddr},  32'd0);
        chk("rst_wb_wdata",  wb_wdata,           32'd0);
        chk("rst_fwd_a_hit", {31'd0, fwd_a_hit}, 32'd0);

        rst = 1'b1;
        drive(1'b0, 6'h00, 5'd0, 32'd0);
        tick();
        chk("rel_exe_ready", {31'd0, exe_ready}, 32'd1);
        chk("rel_wb_wen",    {31'd0, wb_wen},    32'd0);

        // single write
        drive(1'b1, 6'h00, 5'd5, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 6'h00, 5'd0, 32'd0);
        chk("sw_wen",     {31'd0, wb_wen},   32'd1);
        chk("sw_waddr",   {27'd0, wb_waddr}, 32'd5);
        chk("sw_wdata",   wb_wdata,          32'hDEAD_BEEF);
        chk("sw_retired", {16'd0, retired_cnt}, 32'd1);
        tick();
        chk("sw_wen_off", {31'd0, wb_wen},   32'd0);

        // backpressure: two accepts fill the FIFO, third is refused
        wb_ready = 1'b0;
        drive(1'b1, 6'h04, 5'd1, 32'h11);
        tick();
        drive(1'b1, 6'h18, 5'd2, 32'h22);
        tick();
        chk("bp_full_ready", {31'd0, exe_ready}, 32'd0);
        chk("bp_head_waddr", {27'd0, wb_waddr},  32'd1);
        chk("bp_retired2",   {16'd0, retired_cnt}, 32'd3);
        drive(1'b1, 6'h00, 5'd3, 32'h33);
        tick();
        chk("bp_no_accept",  {16'd0, retired_cnt}, 32'd3);
        chk("bp_hold_waddr", {27'd0, wb_waddr},  32'd1);
        chk("bp_hold_wdata", wb_wdata,           32'h11);
        drive(1'b0, 6'h00, 5'd0, 32'd0);
        wb_ready = 1'b1;
        tick();
        chk("bp_pop1_waddr", {27'd0, wb_waddr},  32'd2);
        chk("bp_pop1_wdata", wb_wdata,           32'h22);
        chk("bp_pop1_ready", {31'd0, exe_ready}, 32'd1);
        tick();
        chk("bp_drained",    {31'd0, wb_wen},    32'd0);

        // non-writing class and zero destination
        drive(1'b1, 6'h20, 5'd7, 32'h77);
        tick();
        chk("nw_store_wen", {31'd0, wb_wen}, 32'd0);
        drive(1'b1, 6'h10, 5'd0, 32'h88);
        tick();
        drive(1'b0, 6'h00, 5'd0, 32'd0);
        chk("nw_zero_wen",  {31'd0, wb_wen}, 32'd0);
        chk("nw_retired",   {16'd0, retired_cnt}, 32'd5);

        // forwarding priority: newest r3 wins
        wb_ready = 1'b0;
        drive(1'b1, 6'h00, 5'd3, 32'hAAAA);
        tick();
        drive(1'b1, 6'h00, 5'd3, 32'hBBBB);
        tick();
        drive(1'b0, 6'h00, 5'd0, 32'd0);
        rs_a = 5'd3; rs_b = 5'd4;
        #1;
        chk("fw_a_hit",  {31'd0, fwd_a_hit}, 32'd1);
        chk("fw_a_data", fwd_a_data,         32'hBBBB);
        chk("fw_b_hit",  {31'd0, fwd_b_hit}, 32'd0);
        chk("fw_b_data", fwd_b_data,         32'd0);
        rs_a = 5'd0;
        #1;
        chk("fw_a0_hit", {31'd0, fwd_a_hit}, 32'd0);
        rs_a = 5'd3;

        // drain head, then simultaneous push/pop at count=1
        wb_ready = 1'b1;
        tick();
        chk("pp_head_data", wb_wdata,   32'hBBBB);
        chk("pp_fwd_data",  fwd_a_data, 32'hBBBB);
        drive(1'b1, 6'h00, 5'd9, 32'h99);
        tick();
        drive(1'b0, 6'h00, 5'd0, 32'd0);
        chk("pp_wen",   {31'd0, wb_wen},   32'd1);
        chk("pp_waddr", {27'd0, wb_waddr}, 32'd9);
        chk("pp_wdata", wb_wdata,          32'h99);
        chk("pp_fwd3",  {31'd0, fwd_a_hit}, 32'd0);
        tick();
        chk("pp_empty", {31'd0, wb_wen},   32'd0);
        chk("pp_retired", {16'd0, retired_cnt}, 32'd8);

        // reset while full
        wb_ready = 1'b0;
        drive(1'b1, 6'h00, 5'd10, 32'hA0);
        tick();
        drive(1'b1, 6'h00, 5'd11, 32'hB1);
        tick();
        drive(1'b0, 6'h00, 5'd0, 32'd0);
        chk("mr_full", {31'd0, exe_ready}, 32'd0);
        rs_a = 5'd10;
        rst = 1'b0;
        #1;
        chk("mr_wen_async",  {31'd0, wb_wen},    32'd0);
        chk("mr_ready",      {31'd0, exe_ready}, 32'd0);
        chk("mr_retired",    {16'd0, retired_cnt}, 32'd0);
        chk("mr_fwd_hit",    {31'd0, fwd_a_hit}, 32'd0);
        tick();
        rst = 1'b1;
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_no_stale", {31'd0, wb_wen}, 32'd0);
        end

        // retired counter wrap, using non-writing ops
        drive(1'b1, 6'h30, 5'd0, 32'd0);
        repeat (65535) tick();
        chk("wrap_ffff", {16'd0, retired_cnt}, 32'h0000_FFFF);
        tick();
        chk("wrap_zero", {16'd0, retired_cnt}, 32'd0);
        chk("wrap_wen",  {31'd0, wb_wen},      32'd0);
        drive(1'b0, 6'h00, 5'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/exe_wb_stage.md
Name: exe_wb_stage

Overview:
- Drain end of the EXE stage.
- Consumes results produced from the ID/EXE register outputs (ALU result, destination address, opcode) under a valid/ready handshake.
- Buffers up to two pending register-file writes in a 2-entry FIFO and drives the register-file write port, which may back-pressure.
- Exposes forwarding lookups on pending writes so ID-stage reads see results not yet committed.

Parameters:
- DSIZE, 32, data width (matches `DSIZE)
- ASIZE, 5, register address width (matches `ASIZE)
- CNTW, 16, retired-instruction counter width

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- exe_valid  in  1  EXE presents a result this cycle
- exe_ready  out  1  stage can accept a result
- exe_result  in  DSIZE  ALU/sign-extended result
- exe_waddr  in  ASIZE  destination register (ID/EXE mux_out)
- exe_op  in  6  opcode carried through the pipe
- wb_wen  out  1  register-file write request
- wb_ready  in  1  register file accepts the write this cycle
- wb_waddr  out  ASIZE  write address
- wb_wdata  out  DSIZE  write data
- rs_a  in  ASIZE  ID read address A for forwarding
- rs_b  in  ASIZE  ID read address B for forwarding
- fwd_a_hit  out  1  pending write matches rs_a
- fwd_a_data  out  DSIZE  forwarded data for rs_a
- fwd_b_hit  out  1  pending write matches rs_b
- fwd_b_data  out  DSIZE  forwarded data for rs_b
- retired_cnt  out  CNTW  count of accepted results

Behaviour:
- Reset (rst low, asynchronous): FIFO count=0, rd/wr pointers=0, entry storage=0, retired_cnt=0.
- Reset outputs: wb_wen=0, wb_waddr=0, wb_wdata=0, fwd_*_hit=0, fwd_*_data=0, exe_ready=0 while rst is low.
- Reset mid-operation: pending writes are discarded and are never emitted.
- exe_ready = rst && (count<2). It is a function of registered count only; there is no combinational path from wb_ready.
- Accept: exe_valid && exe_ready at a posedge. Every accept increments retired_cnt, which wraps modulo 2^CNTW.
- Opcode class is exe_op[5:4]:
  - 00 (R-type) and 01 (I-type) are writing.
  - 10 (store) and 11 (branch) are non-writing.
- Enqueue only a writing op with exe_waddr != 0. All other accepted results are dropped: the handshake completes, but nothing is enqueued.
- Latency: a result enqueued at edge N appears as wb_wen=1 with its address/data in the cycle after edge N, provided the FIFO was empty.
- wb_wen = (count != 0). wb_waddr/wb_wdata come from the head entry and are held stable while wb_wen && !wb_ready.
- Pop: wb_wen && wb_ready at a posedge.
- Simultaneous push and pop at count=1: count stays 1, the head advances and the new entry becomes the tail.
- Push at count=2 cannot occur, because exe_ready is low.
- Pop at count=0 is ignored.
- Pointers are 1 bit each and wrap 1->0.
- Write order is strict FIFO. No reordering and no merging of same-address entries.
- Forwarding (combinational over registered entries):
  - fwd_x_hit=1 if any valid entry has waddr==rs_x and rs_x != 0.
  - fwd_x_data is the newest matching entry (tail before head). It is 0 on a miss.
  - The entry being popped this cycle is still visible until the edge.
- Unknown/X on exe_op while exe_valid=0 must not affect state.

Decomposition:
- Shared package/define file:
  - DSIZE and ASIZE (existing defines).
  - Opcode class constants: OPC_RTYPE=2'b00, OPC_ITYPE=2'b01, OPC_STORE=2'b10, OPC_BRANCH=2'b11.
  - An is_writing(op) function.
- One sub-module: wb_fifo2, a 2-entry FIFO {waddr,wdata} with count and a per-entry peek port for forwarding.
- Forwarding compare and the counter stay in exe_wb_stage.

Test Plan:
- Reset: hold rst low 3 cycles with exe_valid=1 -> exe_ready=0, wb_wen=0, retired_cnt=0. Release -> exe_ready=1 next cycle.
- Single write: op=6'h00, waddr=5, result=32'hDEAD_BEEF, wb_ready=1 -> one cycle later wb_wen=1, waddr=5, wdata=DEADBEEF for exactly one cycle; retired_cnt=1.
- Backpressure: wb_ready=0, push results to r1=0x11 and r2=0x22 -> exe_ready=0 after the second accept; third exe_valid is not accepted. Raise wb_ready -> writes r1 then r2 in order; exe_ready=1 after the first pop.
- Non-writing/zero-dest: op=6'h20 (store) waddr=7, then op=6'h10 waddr=0 -> both accepted, retired_cnt=+2, wb_wen stays 0.
- Forwarding priority: wb_ready=0, enqueue r3=0xAAAA then r3=0xBBBB; rs_a=3, rs_b=4 -> fwd_a_hit=1, fwd_a_data=0xBBBB, fwd_b_hit=0. With rs_a=0 -> fwd_a_hit=0.
- Simultaneous push/pop and mid-op reset:
  - With count=1 and wb_ready=1, accept a new result -> count stays 1 and the next cycle emits the new entry.
  - Assert rst with count=2 -> wb_wen=0 immediately (asynchronous) and no stale write after release.
  - retired_cnt wraps from 16'hFFFF to 0.
